mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences and arbitrates accesses to the single-port data memory shared by the core's load/store path and the host/debug loader port.
- Core side: the LOAD/STORE address and write data come from the address generator; the core stalls while its request is pending.
- Host side: the same memory is used for program/data download and readback.
- Grants one requester at a time, drives the memory strobes, waits the fixed memory read latency, returns read data and pulses an acknowledge.

Parameters:
addr_width, 16, memory address width
data_width, 32, memory data width
mem_latency, 2, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
core_req  input  1  core access request, level, held until core_ack
core_we  input  1  1 = store, 0 = load
core_addr  input  addr_width  core address
core_wdata  input  data_width  core store data
core_ack  output  1  one-cycle completion pulse to core
core_stall  output  1  core_req & ~core_ack
host_req  input  1  host access request, level, held until host_ack
host_we  input  1  1 = write, 0 = read
host_addr  input  addr_width  host address
host_wdata  input  data_width  host write data
host_ack  output  1  one-cycle completion pulse to host
rd_data  output  data_width  read data, valid in the ack cycle of a read
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  addr_width  memory address
mem_wdata  output  data_width  memory write data
mem_rdata  input  data_width  memory read data
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: synchronous, overrides everything, including mid-transaction.
  - State to IDLE.
  - All outputs 0 (core_stall follows core_req).
  - Counter 0; last_grant = host, so the core wins the first tie.
- All outputs except core_stall are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples core_req and host_req.
  - One request: grant it.
  - Both requests: grant the one not equal to last_grant (round-robin), then update last_grant.
  - On grant: latch we/addr/wdata of the grantee into mem_we/mem_addr/mem_wdata and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_en = 1 for exactly this cycle.
  - Write: go to DONE.
  - Read: load counter with mem_latency and go to WAIT.
- WAIT:
  - mem_en = 0; counter decrements each cycle.
  - When counter == 1: capture mem_rdata into rd_data and go to DONE.
  - Net effect: mem_rdata is sampled in the cycle mem_latency cycles after the ISSUE cycle.
- DONE:
  - Grantee's ack = 1 for one cycle; go to IDLE.
  - rd_data holds its last value until the next read capture; writes do not change it.
- Latency, counted from the cycle the request is first seen in IDLE (cycle 0):
  - Write ack in cycle 2.
  - Read ack in cycle 2 + mem_latency.
- Handshake:
  - A requester must deassert req, or present a new request, in the cycle after its ack.
  - A req still high in IDLE after DONE is a new request.
  - The address/data/we inputs are don't-care after the IDLE sampling cycle.
  - A req dropped mid-transaction is a protocol violation: the transaction still completes and ack still pulses.
- Fairness: under continuous requests from both sides, grants alternate core, host, core, host...
- mem_addr, mem_we and mem_wdata hold their values from grant until the next grant. mem_en is the only access qualifier.
- Width rules: no arithmetic on addresses or data. The counter is 4 bits.

Test Plan:
1. Reset, then core load addr 0x0040, mem_latency=2, memory returns 0xDEADBEEF -> mem_en high cycle 1 with mem_we=0, mem_addr=0x0040; core_ack and rd_data=0xDEADBEEF in cycle 4; core_stall high cycles 0-3.
2. Core store addr 0x0010 data 0x12345678 -> mem_en=mem_we=1 in cycle 1 with that addr/data; core_ack in cycle 2; rd_data unchanged.
3. core_req and host_req both asserted in the same cycle after reset, both loads -> core served first; host mem_en follows core DONE plus one IDLE cycle; host_ack later; exactly one ack per request.
4. Both requesters hold requests continuously for 4 transactions -> grant order core, host, core, host; never two mem_en pulses closer than 2 cycles.
5. rst asserted in WAIT of a host read -> next cycle state IDLE, all outputs 0, no host_ack. Core and host requesting together after reset -> core granted first.
6. mem_latency=1, host read of 0x00FF returning 0xA5A5A5A5 -> host_ack and rd_data=0xA5A5A5A5 in cycle 3.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between the data-memory access controller, its two requesters and the memory.
// slave: controller view (requests and mem_rdata in; acks, strobes and read data out).
// master: requester/memory view, the mirror image of slave.
interface mem_access_ctrl_if #(
  parameter int addr_width = 16,
  parameter int data_width = 32
);
  // core load/store side
  logic                  core_req;
  logic                  core_we;
  logic [addr_width-1:0] core_addr;
  logic [data_width-1:0] core_wdata;
  logic                  core_ack;
  logic                  core_stall;

  // host/debug loader side
  logic                  host_req;
  logic                  host_we;
  logic [addr_width-1:0] host_addr;
  logic [data_width-1:0] host_wdata;
  logic                  host_ack;

  // shared read return
  logic [data_width-1:0] rd_data;

  // single-port memory side
  logic                  mem_en;
  logic                  mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic [data_width-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_rdata,
    output core_ack, core_stall, host_ack, rd_data,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_rdata,
    input  core_ack, core_stall, host_ack, rd_data,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates core and host accesses to one single-port data memory, round-robin on ties.
// Latency: write ack 2 cycles after the request is seen in IDLE, read ack 2 + mem_latency.
// Backpressure: one access in flight; the losing/waiting requester holds req (core sees core_stall).
module mem_access_ctrl #(
  parameter int addr_width  = 16,
  parameter int data_width  = 32,
  // cycles from the mem_en cycle to valid mem_rdata, legal 1..15 (4-bit counter)
  parameter int mem_latency = 2
) (
  input logic              clk,
  input logic              rst,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] lat_init = 4'(mem_latency);

  state_t state, state_nxt;

  // wait counter and arbitration bookkeeping
  logic [3:0] cnt, cnt_nxt;
  logic       grant_host, grant_host_nxt;   // owner of the access in flight
  logic       last_host, last_host_nxt;     // owner of the most recent grant

  // registered outputs
  logic                  mem_en_q, mem_en_nxt;
  logic                  mem_we_q, mem_we_nxt;
  logic [addr_width-1:0] mem_addr_q, mem_addr_nxt;
  logic [data_width-1:0] mem_wdata_q, mem_wdata_nxt;
  logic [data_width-1:0] rd_data_q, rd_data_nxt;
  logic                  core_ack_q, core_ack_nxt;
  logic                  host_ack_q, host_ack_nxt;
  logic                  busy_q, busy_nxt;

  logic any_req;
  logic pick_host;

  // Requester selection: single request wins outright, a tie goes to whoever was not granted last.
  always_comb begin
    any_req   = bus.core_req | bus.host_req;
    pick_host = (bus.core_req & bus.host_req) ? ~last_host : bus.host_req;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: writes skip WAIT, reads wait until the counter expires.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_we_q ? DONE : WAIT;
      WAIT:    if (cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered so they are decoded from state_nxt.
  always_comb begin
    cnt_nxt        = cnt;
    grant_host_nxt = grant_host;
    last_host_nxt  = last_host;
    mem_we_nxt     = mem_we_q;
    mem_addr_nxt   = mem_addr_q;
    mem_wdata_nxt  = mem_wdata_q;
    rd_data_nxt    = rd_data_q;

    case (state)
      IDLE: begin
        if (any_req) begin
          // grantee's command is captured here; the inputs are don't-care afterwards
          grant_host_nxt = pick_host;
          last_host_nxt  = pick_host;
          mem_we_nxt     = pick_host ? bus.host_we    : bus.core_we;
          mem_addr_nxt   = pick_host ? bus.host_addr  : bus.core_addr;
          mem_wdata_nxt  = pick_host ? bus.host_wdata : bus.core_wdata;
        end
      end
      ISSUE: begin
        if (!mem_we_q) cnt_nxt = lat_init;
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // counter at 1 is exactly mem_latency cycles after the ISSUE cycle
        if (cnt == 4'd1) rd_data_nxt = bus.mem_rdata;
      end
      default: begin
      end
    endcase

    mem_en_nxt   = (state_nxt == ISSUE);
    busy_nxt     = (state_nxt != IDLE);
    core_ack_nxt = (state_nxt == DONE) & ~grant_host_nxt;
    host_ack_nxt = (state_nxt == DONE) &  grant_host_nxt;
  end

  // Output and datapath registers; reset clears everything and biases the first tie to the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      grant_host  <= 1'b0;
      last_host   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
      core_ack_q  <= 1'b0;
      host_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      grant_host  <= grant_host_nxt;
      last_host   <= last_host_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      rd_data_q   <= rd_data_nxt;
      core_ack_q  <= core_ack_nxt;
      host_ack_q  <= host_ack_nxt;
      busy_q      <= busy_nxt;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.core_ack   = core_ack_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.busy       = busy_q;
  // the only combinational output: stall drops in the ack cycle itself
  assign bus.core_stall = bus.core_req & ~core_ack_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level timing/data model and a behavioural memory.
module tb_mem_access_ctrl;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int ack_seq[$];

  mem_access_ctrl_if #(.addr_width(AW), .data_width(DW)) bus_a ();
  mem_access_ctrl_if #(.addr_width(AW), .data_width(DW)) bus_b ();

  mem_access_ctrl #(.addr_width(AW), .data_width(DW), .mem_latency(LAT_A)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mem_access_ctrl #(.addr_width(AW), .data_width(DW), .mem_latency(LAT_B)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // memory for dut_a: data valid only exactly LAT_A cycles after the mem_en cycle
  bit   [31:0]       mem_a [256];
  logic [15:0]       pipe_vld_a = '0;
  logic [15:0][31:0] pipe_dat_a;
  logic              pre_we = 1'b0;
  logic [7:0]        pre_addr = '0;
  logic [31:0]       pre_dat = '0;

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_dat;
    else if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    pipe_vld_a <= {pipe_vld_a[14:0], bus_a.mem_en && !bus_a.mem_we};
    pipe_dat_a <= {pipe_dat_a[14:0], mem_a[bus_a.mem_addr[7:0]]};
  end
  assign bus_a.mem_rdata = pipe_vld_a[LAT_A-1] ? pipe_dat_a[LAT_A-1] : 32'hBADBAD00;

  // memory for dut_b (latency 1): fixed pattern, 0x00FF holds 0xA5A5A5A5
  logic        vld_b = 1'b0;
  logic [31:0] dat_b = '0;
  always @(posedge clk) begin
    vld_b <= bus_b.mem_en && !bus_b.mem_we;
    dat_b <= (bus_b.mem_addr == 16'h00FF) ? 32'hA5A5A5A5 : {16'h0, bus_b.mem_addr};
  end
  assign bus_b.mem_rdata = vld_b ? dat_b : 32'hBADBAD01;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.core_req = 0; bus_a.core_we = 0; bus_a.core_addr = '0; bus_a.core_wdata = '0;
    bus_a.host_req = 0; bus_a.host_we = 0; bus_a.host_addr = '0; bus_a.host_wdata = '0;
    bus_b.core_req = 0; bus_b.core_we = 0; bus_b.core_addr = '0; bus_b.core_wdata = '0;
    bus_b.host_req = 0; bus_b.host_we = 0; bus_b.host_addr = '0; bus_b.host_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic preload_a(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1; pre_addr = a; pre_dat = d;
    tick();
    pre_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    bus_a.core_req = 1; bus_a.host_req = 1; bus_a.core_addr = 16'h1234;
    repeat (2) tick();
    @(negedge clk);
    tests_run++;
    if ({bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data,
         bus_a.core_ack, bus_a.host_ack, bus_a.busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_a: got en=%b addr=%h rd=%h busy=%b, required all 0",
               bus_a.mem_en, bus_a.mem_addr, bus_a.rd_data, bus_a.busy);
    end
    tests_run++;
    if ({bus_b.mem_en, bus_b.rd_data, bus_b.core_ack, bus_b.host_ack, bus_b.busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs_b: got en=%b rd=%h busy=%b, required all 0",
               bus_b.mem_en, bus_b.rd_data, bus_b.busy);
    end
    tests_run++;
    if (bus_a.core_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_stall_hi: got %b required 1", bus_a.core_stall);
    end
    bus_a.core_req = 0;
    #1;
    tests_run++;
    if (bus_a.core_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall_lo: got %b required 0", bus_a.core_stall);
    end
    bus_a.host_req = 0;
    tick();
    rst = 0;
    tick();
    @(negedge clk);
    tests_run++;
    if (bus_a.busy !== 1'b0 || bus_a.mem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got busy=%b en=%b required 0 0", bus_a.busy, bus_a.mem_en);
    end
  endtask

  task automatic test_core_load();
    preload_a(8'h40, 32'hDEADBEEF);
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (c == 0) begin
        bus_a.core_req = 1; bus_a.core_we = 0; bus_a.core_addr = 16'h0040; bus_a.core_wdata = $urandom;
      end
      if (c == 5) bus_a.core_req = 0;
      @(negedge clk);
      tests_run++;
      if (bus_a.mem_en !== (c == 1)) begin
        tests_failed++; $display("FAIL load_mem_en c%0d: got %b required %b", c, bus_a.mem_en, c == 1);
      end
      tests_run++;
      if (bus_a.core_ack !== (c == 4)) begin
        tests_failed++; $display("FAIL load_ack c%0d: got %b required %b", c, bus_a.core_ack, c == 4);
      end
      tests_run++;
      if (bus_a.core_stall !== (c <= 3)) begin
        tests_failed++; $display("FAIL load_stall c%0d: got %b required %b", c, bus_a.core_stall, c <= 3);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 16'h0040) begin
          tests_failed++;
          $display("FAIL load_cmd: got we=%b addr=%h required 0 0040", bus_a.mem_we, bus_a.mem_addr);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (bus_a.rd_data !== 32'hDEADBEEF) begin
          tests_failed++; $display("FAIL load_rd_data: got %h required deadbeef", bus_a.rd_data);
        end
      end
    end
  endtask

  // runs straight after test_core_load, so rd_data must still hold 0xDEADBEEF
  task automatic test_core_store();
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) begin
        bus_a.core_req = 1; bus_a.core_we = 1; bus_a.core_addr = 16'h0010; bus_a.core_wdata = 32'h12345678;
      end
      if (c == 3) bus_a.core_req = 0;
      @(negedge clk);
      tests_run++;
      if (bus_a.mem_en !== (c == 1)) begin
        tests_failed++; $display("FAIL store_mem_en c%0d: got %b required %b", c, bus_a.mem_en, c == 1);
      end
      tests_run++;
      if (bus_a.core_ack !== (c == 2)) begin
        tests_failed++; $display("FAIL store_ack c%0d: got %b required %b", c, bus_a.core_ack, c == 2);
      end
      tests_run++;
      if (bus_a.rd_data !== 32'hDEADBEEF) begin
        tests_failed++; $display("FAIL store_rd_hold c%0d: got %h required deadbeef", c, bus_a.rd_data);
      end
      if (c == 1) begin
        tests_run++;
        if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 16'h0010 || bus_a.mem_wdata !== 32'h12345678) begin
          tests_failed++;
          $display("FAIL store_cmd: got we=%b addr=%h wdata=%h required 1 0010 12345678",
                   bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        end
      end
    end
  endtask

  task automatic test_tie();
    int cack_n = 0;
    int hack_n = 0;
    preload_a(8'h20, 32'hC0DE0020);
    preload_a(8'h30, 32'hC0DE0030);
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      if (c == 0) begin
        bus_a.core_req = 1; bus_a.core_we = 0; bus_a.core_addr = 16'h0020;
        bus_a.host_req = 1; bus_a.host_we = 0; bus_a.host_addr = 16'h0030;
      end
      if (c == 5)  bus_a.core_req = 0;
      if (c == 10) bus_a.host_req = 0;
      @(negedge clk);
      if (bus_a.core_ack === 1'b1) cack_n++;
      if (bus_a.host_ack === 1'b1) hack_n++;
      tests_run++;
      if (bus_a.mem_en !== (c == 1 || c == 6)) begin
        tests_failed++; $display("FAIL tie_mem_en c%0d: got %b required %b", c, bus_a.mem_en, c == 1 || c == 6);
      end
      tests_run++;
      if (bus_a.core_ack !== (c == 4) || bus_a.host_ack !== (c == 9)) begin
        tests_failed++;
        $display("FAIL tie_acks c%0d: got core=%b host=%b required %b %b", c, bus_a.core_ack, bus_a.host_ack, c == 4, c == 9);
      end
      if (c == 6) begin
        tests_run++;
        if (bus_a.mem_addr !== 16'h0030) begin
          tests_failed++; $display("FAIL tie_host_addr: got %h required 0030", bus_a.mem_addr);
        end
      end
      if (c == 4 || c == 9) begin
        tests_run++;
        if (bus_a.rd_data !== ((c == 4) ? 32'hC0DE0020 : 32'hC0DE0030)) begin
          tests_failed++; $display("FAIL tie_rd_data c%0d: got %h", c, bus_a.rd_data);
        end
      end
    end
    tests_run++;
    if (cack_n != 1 || hack_n != 1) begin
      tests_failed++; $display("FAIL tie_ack_count: got core=%0d host=%0d required 1 1", cack_n, hack_n);
    end
  endtask

  // Randomized traffic on dut_a checked against a transaction model: an access granted in
  // cycle g issues in g+1 and acks in g+2 (write) or g+2+LAT_A (read); the controller is free
  // again the cycle after the ack. Must start right after do_reset.
  task automatic test_random(input string tag, input int ncyc, input int req_pct);
    bit          m_busy = 0;
    bit          m_host = 0;
    bit          m_we = 0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    bit          last_host = 1;
    int          t_issue = 0;
    int          t_ack = 0;
    int          last_en = -10;
    logic [15:0] e_addr = '0;
    logic        e_we = 0;
    logic [31:0] e_wdata = '0;
    logic [31:0] e_rd = '0;
    logic        e_en, e_cack, e_hack;
    bit          cack_seen = 0;
    bit          hack_seen = 0;
    bit [31:0]   ref_mem [256];
    ref_mem = mem_a;
    ack_seq.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) tick();
      if (cack_seen || !bus_a.core_req) begin
        bus_a.core_req = ($urandom_range(99) < req_pct);
        bus_a.core_we = 1'($urandom_range(1)); bus_a.core_addr = 16'($urandom_range(31)); bus_a.core_wdata = $urandom;
      end else if (m_busy && !m_host) begin
        bus_a.core_we = 1'($urandom_range(1)); bus_a.core_addr = 16'($urandom); bus_a.core_wdata = $urandom;
      end
      if (hack_seen || !bus_a.host_req) begin
        bus_a.host_req = ($urandom_range(99) < req_pct);
        bus_a.host_we = 1'($urandom_range(1)); bus_a.host_addr = 16'($urandom_range(31)); bus_a.host_wdata = $urandom;
      end else if (m_busy && m_host) begin
        bus_a.host_we = 1'($urandom_range(1)); bus_a.host_addr = 16'($urandom); bus_a.host_wdata = $urandom;
      end
      @(negedge clk);
      e_en   = m_busy && (c == t_issue);
      e_cack = m_busy && (c == t_ack) && !m_host;
      e_hack = m_busy && (c == t_ack) && m_host;
      if ((e_cack || e_hack) && !m_we) e_rd = ref_mem[m_addr[7:0]];
      tests_run++;
      if (bus_a.mem_en !== e_en) begin
        tests_failed++; $display("FAIL %s c%0d mem_en: got %b required %b", tag, c, bus_a.mem_en, e_en);
      end
      tests_run++;
      if (bus_a.core_ack !== e_cack || bus_a.host_ack !== e_hack) begin
        tests_failed++;
        $display("FAIL %s c%0d acks: got core=%b host=%b required %b %b", tag, c, bus_a.core_ack, bus_a.host_ack, e_cack, e_hack);
      end
      tests_run++;
      if (bus_a.busy !== m_busy) begin
        tests_failed++; $display("FAIL %s c%0d busy: got %b required %b", tag, c, bus_a.busy, m_busy);
      end
      tests_run++;
      if (bus_a.mem_addr !== e_addr || bus_a.mem_we !== e_we || bus_a.mem_wdata !== e_wdata) begin
        tests_failed++;
        $display("FAIL %s c%0d mem_cmd: got %h/%b/%h required %h/%b/%h", tag, c,
                 bus_a.mem_addr, bus_a.mem_we, bus_a.mem_wdata, e_addr, e_we, e_wdata);
      end
      tests_run++;
      if (bus_a.rd_data !== e_rd) begin
        tests_failed++; $display("FAIL %s c%0d rd_data: got %h required %h", tag, c, bus_a.rd_data, e_rd);
      end
      tests_run++;
      if (bus_a.core_stall !== (bus_a.core_req & ~e_cack)) begin
        tests_failed++; $display("FAIL %s c%0d core_stall: got %b required %b", tag, c, bus_a.core_stall, bus_a.core_req & ~e_cack);
      end
      if (bus_a.mem_en === 1'b1) begin
        tests_run++;
        if (c - last_en < 2) begin
          tests_failed++; $display("FAIL %s c%0d mem_en_spacing: got gap %0d required >= 2", tag, c, c - last_en);
        end
        last_en = c;
      end
      if (bus_a.core_ack === 1'b1) ack_seq.push_back(0);
      if (bus_a.host_ack === 1'b1) ack_seq.push_back(1);
      cack_seen = (bus_a.core_ack === 1'b1);
      hack_seen = (bus_a.host_ack === 1'b1);
      if (m_busy && c == t_ack) begin
        m_busy = 0;
      end else if (!m_busy && (bus_a.core_req || bus_a.host_req)) begin
        m_host    = (bus_a.core_req && bus_a.host_req) ? !last_host : bus_a.host_req;
        last_host = m_host;
        m_we      = m_host ? bus_a.host_we    : bus_a.core_we;
        m_addr    = m_host ? bus_a.host_addr  : bus_a.core_addr;
        m_wdata   = m_host ? bus_a.host_wdata : bus_a.core_wdata;
        if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
        t_issue = c + 1;
        t_ack   = c + (m_we ? 2 : 2 + LAT_A);
        m_busy  = 1;
        e_addr = m_addr; e_we = m_we; e_wdata = m_wdata;
      end
    end
    bus_a.core_req = 0;
    bus_a.host_req = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    test_random("b2b", 40, 100);
    tests_run++;
    if (ack_seq.size() < 4) begin
      tests_failed++; $display("FAIL b2b_ack_count: got %0d required >= 4", ack_seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (ack_seq[i] != (i % 2)) begin
          tests_failed++; $display("FAIL b2b_order[%0d]: got %0d required %0d (0=core 1=host)", i, ack_seq[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus_a.host_req = 1; bus_a.host_we = 0; bus_a.host_addr = 16'h0033;
    tick();
    tick();
    rst = 1;
    bus_a.host_req = 0;
    @(negedge clk);
    tests_run++;
    if (bus_a.busy !== 1'b1 || bus_a.mem_en !== 1'b0) begin
      tests_failed++; $display("FAIL rstwait_in_wait: got busy=%b en=%b required 1 0", bus_a.busy, bus_a.mem_en);
    end
    tick();
    rst = 0;
    @(negedge clk);
    tests_run++;
    if ({bus_a.mem_en, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata, bus_a.rd_data,
         bus_a.core_ack, bus_a.host_ack, bus_a.busy} !== '0) begin
      tests_failed++;
      $display("FAIL rstwait_outputs: got en=%b addr=%h hack=%b busy=%b required all 0",
               bus_a.mem_en, bus_a.mem_addr, bus_a.host_ack, bus_a.busy);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      tests_run++;
      if (bus_a.host_ack !== 1'b0 || bus_a.busy !== 1'b0) begin
        tests_failed++; $display("FAIL rstwait_no_ack c%0d: got hack=%b busy=%b required 0 0", c, bus_a.host_ack, bus_a.busy);
      end
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin
        bus_a.core_req = 1; bus_a.core_we = 0; bus_a.core_addr = 16'h0011;
        bus_a.host_req = 1; bus_a.host_we = 0; bus_a.host_addr = 16'h0022;
      end
      if (c == 5) begin bus_a.core_req = 0; bus_a.host_req = 0; end
      @(negedge clk);
      if (c == 1) begin
        tests_run++;
        if (bus_a.mem_en !== 1'b1 || bus_a.mem_addr !== 16'h0011) begin
          tests_failed++; $display("FAIL rstwait_core_first: got en=%b addr=%h required 1 0011", bus_a.mem_en, bus_a.mem_addr);
        end
      end
      if (c == 4) begin
        tests_run++;
        if (bus_a.core_ack !== 1'b1 || bus_a.host_ack !== 1'b0) begin
          tests_failed++; $display("FAIL rstwait_core_ack: got core=%b host=%b required 1 0", bus_a.core_ack, bus_a.host_ack);
        end
      end
    end
  endtask

  task automatic test_lat1();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      if (c == 0) begin bus_b.host_req = 1; bus_b.host_we = 0; bus_b.host_addr = 16'h00FF; end
      if (c == 4) bus_b.host_req = 0;
      @(negedge clk);
      tests_run++;
      if (bus_b.mem_en !== (c == 1)) begin
        tests_failed++; $display("FAIL lat1_mem_en c%0d: got %b required %b", c, bus_b.mem_en, c == 1);
      end
      tests_run++;
      if (bus_b.host_ack !== (c == 3) || bus_b.core_ack !== 1'b0) begin
        tests_failed++; $display("FAIL lat1_ack c%0d: got host=%b core=%b required %b 0", c, bus_b.host_ack, bus_b.core_ack, c == 3);
      end
      if (c == 2 || c == 3) begin
        tests_run++;
        if (bus_b.rd_data !== ((c == 3) ? 32'hA5A5A5A5 : 32'h0)) begin
          tests_failed++; $display("FAIL lat1_rd_data c%0d: got %h", c, bus_b.rd_data);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_core_load();
    test_core_store();
    test_tie();
    test_back_to_back();
    test_reset_mid_wait();
    test_lat1();
    do_reset();
    test_random("rand_busy", 2000, 70);
    do_reset();
    test_random("rand_sparse", 1500, 25);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
